// File: rtl/exec_pkg.sv
// Shared types and helpers for the execution unit: opcodes, FSM states,
// flag bit positions and the shift-class opcode test.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_CMP = 4'd5,
    OP_MOV = 4'd6,
    OP_SLL = 4'd8,
    OP_ROL = 4'd9,
    OP_SRL = 4'd10,
    OP_SRA = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Opcodes 8..11 are exactly the shift/rotate group.
  function automatic logic is_shift(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/exec_unit_alu_core.sv
// Combinational ALU for the single-cycle ops; shift ops pass b through with
// C=0 so a zero-amount shift can complete on the same path.
module alu_core
  import exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o,
  output logic             wr_o,
  output logic             legal_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;
  logic           c_s;
  logic           v_s;

  assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_s = {1'b0, a_i} - {1'b0, b_i};

  // Result, carry/overflow and write-enable selection per opcode.
  always_comb begin
    result_o = '0;
    c_s      = 1'b0;
    v_s      = 1'b0;
    wr_o     = 1'b1;
    legal_o  = 1'b1;
    case (op_e'(op_i))
      OP_ADD: begin
        result_o = sum_s[WIDTH-1:0];
        c_s      = sum_s[WIDTH];
        v_s      = ~(a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (sum_s[WIDTH-1] ^ a_i[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        result_o = diff_s[WIDTH-1:0];
        c_s      = diff_s[WIDTH];
        v_s      = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (diff_s[WIDTH-1] ^ a_i[WIDTH-1]);
        if (op_e'(op_i) == OP_CMP) begin
          wr_o = 1'b0;
        end else begin
          wr_o = 1'b1;
        end
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_MOV, OP_SLL, OP_ROL, OP_SRL, OP_SRA: result_o = b_i;
      default: begin
        legal_o = 1'b0;
        wr_o    = 1'b0;
      end
    endcase
    flags_o         = '0;
    flags_o[FLAG_S] = result_o[WIDTH-1];
    flags_o[FLAG_Z] = ~|result_o;
    flags_o[FLAG_C] = c_s;
    flags_o[FLAG_V] = v_s;
  end

endmodule

// File: rtl/exec_unit.sv
// Execution unit: accepts one op at a time, finishes ALU ops in one cycle and
// shift/rotate ops one bit per cycle, then pulses out_valid for one cycle.
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       shamt,
  output logic             out_valid,
  output logic             wb_en,
  output logic [WIDTH-1:0] wb_data,
  output logic [3:0]       flags,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             wb_en_q, wb_en_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH-1:0] alu_res_s;
  logic [3:0]       alu_flags_s;
  logic             alu_wr_s;
  logic             alu_legal_s;
  logic [WIDTH-1:0] step_s;
  logic             step_c_s;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .result_o (alu_res_s),
    .flags_o  (alu_flags_s),
    .wr_o     (alu_wr_s),
    .legal_o  (alu_legal_s)
  );

  // One-bit shift/rotate step of the working value, with the bit moved out.
  always_comb begin
    step_s   = work_q;
    step_c_s = 1'b0;
    case (op_e'(op_q))
      OP_SLL: begin step_s = {work_q[WIDTH-2:0], 1'b0};            step_c_s = work_q[WIDTH-1]; end
      OP_ROL: begin step_s = {work_q[WIDTH-2:0], work_q[WIDTH-1]}; step_c_s = work_q[WIDTH-1]; end
      OP_SRL: begin step_s = {1'b0, work_q[WIDTH-1:1]};            step_c_s = work_q[0];       end
      OP_SRA: begin step_s = {work_q[WIDTH-1], work_q[WIDTH-1:1]}; step_c_s = work_q[0];       end
      default: begin step_s = work_q; step_c_s = 1'b0; end
    endcase
  end

  // FSM next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    wb_en_d     = 1'b0;
    illegal_d   = 1'b0;
    wb_data_d   = wb_data_q;
    flags_d     = flags_q;
    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          op_d       = op;
          work_d     = b;
          if (is_shift(op) && (shamt != 4'd0)) begin
            state_d = ST_SHIFT;
            cnt_d   = shamt;
          end else begin
            state_d     = ST_DONE;
            cnt_d       = 4'd0;
            out_valid_d = 1'b1;
            illegal_d   = ~alu_legal_s;
            wb_en_d     = alu_wr_s;
            if (alu_legal_s) begin
              flags_d = alu_flags_s;
            end else begin
              flags_d = flags_q;
            end
            if (alu_wr_s) begin
              wb_data_d = alu_res_s;
            end else begin
              wb_data_d = wb_data_q;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = step_s;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d         = ST_DONE;
          out_valid_d     = 1'b1;
          wb_en_d         = 1'b1;
          wb_data_d       = step_s;
          flags_d         = '0;
          flags_d[FLAG_S] = step_s[WIDTH-1];
          flags_d[FLAG_Z] = ~|step_s;
          flags_d[FLAG_C] = step_c_s;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        in_ready_d = 1'b1;
      end
      default: begin
        state_d    = ST_IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= 4'd0;
      cnt_q       <= 4'd0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      wb_en_q     <= 1'b0;
      illegal_q   <= 1'b0;
      wb_data_q   <= '0;
      flags_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      wb_en_q     <= wb_en_d;
      illegal_q   <= illegal_d;
      wb_data_q   <= wb_data_d;
      flags_q     <= flags_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign wb_en     = wb_en_q;
  assign illegal   = illegal_q;
  assign wb_data   = wb_data_q;
  assign flags     = flags_q;

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter WIDTH, default 16, datapath width; all data ports use it.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 in_valid  in  1  operation offered this cycle.
REQ-005 in_ready  out  1  unit can accept an operation; high only in IDLE.
REQ-006 op  in  4  opcode: ADD=0, SUB=1, AND=2, OR=3, XOR=4, CMP=5, MOV=6, SLL=8, ROL=9, SRL=10, SRA=11.
REQ-007 a  in  WIDTH  first operand, driven from register-file port ar.
REQ-008 b  in  WIDTH  second operand, driven from register-file port br.
REQ-009 shamt  in  4  shift/rotate amount, 0..15.
REQ-010 out_valid  out  1  one-cycle pulse on operation completion.
REQ-011 wb_en  out  1  register-file write strobe; only ever high together with out_valid.
REQ-012 wb_data  out  WIDTH  result for register-file write.
REQ-013 flags  out  4  {S,Z,C,V}, registered status.
REQ-014 illegal  out  1  one-cycle pulse with out_valid for an undefined opcode.

Function
REQ-015 Accept an operation when in_valid and in_ready are both high; latch op, a, b and shamt on that edge.
REQ-016 FSM has three states: IDLE, SHIFT, DONE.
REQ-017 IDLE -> DONE on accepting a non-shift op, or a shift op with shamt=0.
REQ-018 IDLE -> SHIFT on accepting a shift op with shamt>0; load counter=shamt, working value=b.
REQ-019 In SHIFT, move one bit per cycle and decrement the counter; go to DONE after the cycle in which the counter reaches 0.
REQ-020 DONE lasts exactly one cycle with out_valid=1, then returns to IDLE; in_ready=0 in DONE.
REQ-021 Latency from accept edge to out_valid: 1 cycle for non-shift ops, shamt+1 cycles for shift ops.
REQ-022 ADD: wb_data = a+b; C = carry out; V = signed overflow.
REQ-023 SUB and CMP: compute a-b; C = borrow (1 when a<b unsigned); V = signed overflow.
REQ-024 AND, OR, XOR, MOV (wb_data=b): C=0, V=0.
REQ-025 CMP sets flags with wb_en=0; every other legal op sets wb_en=1.
REQ-026 SLL, ROL, SRL and SRA act on b by shamt bits; SRA replicates the MSB.
REQ-027 For shifts, C = last bit shifted or rotated out (0 when shamt=0); V=0.
REQ-028 For all legal ops: S = result MSB; Z = (result==0).
REQ-029 Update flags only on the out_valid cycle of a legal op; otherwise hold them.
REQ-030 Undefined opcodes (7, 12-15) take the IDLE->DONE path with illegal=1, wb_en=0 and flags unchanged.
REQ-031 Ignore in_valid while not in IDLE; there is no input queue.
REQ-032 wb_data holds its last value outside out_valid.

Reset
REQ-033 On reset assertion, immediately: state=IDLE, counter=0, working value=0, out_valid=0, wb_en=0, illegal=0, wb_data=0, flags=0.
REQ-034 After reset deassertion, in_ready=1.
REQ-035 Reset during SHIFT or DONE abandons the operation and produces no out_valid.

Structure
REQ-036 Shared package exec_pkg holds the opcode enum, the FSM state enum, flag bit indices (S=3, Z=2, C=1, V=0) and the is_shift helper.
REQ-037 Combinational sub-module alu_core computes the non-shift result and flags; exec_unit owns the FSM, the shifter and all registers.

Verification
REQ-038 ADD a=16'h7FFF, b=16'h0001 -> out_valid 1 cycle after accept, wb_data=16'h8000, flags S=1 Z=0 C=0 V=1, wb_en=1.
REQ-039 CMP a=16'h0003, b=16'h0005 -> wb_en=0, flags S=1 Z=0 C=1 V=0, wb_data unchanged.
REQ-040 SRA b=16'h8001, shamt=4 -> in_ready low for 5 cycles, out_valid 5 cycles after accept, wb_data=16'hF800, C=0; SRL b=16'h0010, shamt=5 -> wb_data=0, Z=1, C=1.
REQ-041 ROL b=16'h8001, shamt=0 -> 1-cycle latency, wb_data=16'h8001, C=0; ROL shamt=1 -> wb_data=16'h0003, C=1.
REQ-042 op=4'hC -> illegal=1, wb_en=0, flags retained from the previous op.
REQ-043 Reset asserted mid-SHIFT (SLL shamt=10, after 3 cycles) -> outputs zero immediately, no out_valid, in_ready=1 after deassertion; a back-to-back ADD then completes normally.
